// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: issues imem requests under a credit scheme, tags responses with their PC,
// queues them toward decode and discards stale responses after a redirect. Optional counters: IFETCH_PERF_EN.
module ifetch_queue #(
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] fetch_pc_i,
  input  logic        redirect_i,
  output logic        fetch_stall_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  input  logic        id_ready_i,
  output logic [31:0] perf_discard_cnt_o,
  output logic [31:0] perf_stall_cnt_o,
  output logic        dbg_state_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  typedef enum logic {FETCH = 1'b0, DRAIN = 1'b1} state_e;

  // Handshakes: an imem request transfers on imem_req_o & imem_gnt_i; a response is accepted
  // unconditionally on imem_rvalid_i; decode takes the head on if_valid_o & id_ready_i.
  state_e          state_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [63:0]     fifo_q [DEPTH];
  logic [31:0]     tag_q [MAX_OUT];
  logic [TW-1:0]   tag_wr_q, tag_rd_q;
  logic [OW-1:0]   out_q, out_d;
  logic [OW-1:0]   disc_q, disc_d;
  logic            slots_ok, out_ok, gnt_hs, rsp, drop, wr_en, rd_en;

  function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUT - 1)) ? '0 : p + TW'(1);
  endfunction

  // Credit counts both queued and in-flight instructions so a response always has a free entry.
  assign slots_ok      = (32'(cnt_q) + 32'(out_q)) < 32'(DEPTH);
  assign out_ok        = 32'(out_q) < 32'(MAX_OUT);
  assign imem_req_o    = rstn & (state_q == FETCH) & ~redirect_i & slots_ok & out_ok;
  assign imem_addr_o   = fetch_pc_i;
  assign gnt_hs        = imem_req_o & imem_gnt_i;
  assign fetch_stall_o = ~gnt_hs;
  assign rsp           = imem_rvalid_i & (out_q != '0);
  assign drop          = rsp & (disc_q != '0);
  assign wr_en         = rsp & ~drop & ~redirect_i;
  assign if_valid_o    = (cnt_q != '0);
  assign rd_en         = if_valid_o & id_ready_i;
  assign if_pc_o       = fifo_q[rd_ptr_q][63:32];
  assign if_inst_o     = fifo_q[rd_ptr_q][31:0];
  assign dbg_state_o   = state_q;

  always_comb begin
    out_d = out_q;
    if (gnt_hs && !rsp)      out_d = out_q + OW'(1);
    else if (!gnt_hs && rsp) out_d = out_q - OW'(1);
    disc_d = disc_q;
    if (redirect_i) disc_d = out_d;
    else if (drop)  disc_d = disc_q - OW'(1);
    cnt_d = cnt_q;
    if (redirect_i)          cnt_d = '0;
    else if (wr_en && !rd_en) cnt_d = cnt_q + CW'(1);
    else if (!wr_en && rd_en) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q    <= '0;
      disc_q   <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
    end else begin
      out_q  <= out_d;
      disc_q <= disc_d;
      cnt_q  <= cnt_d;
      if (redirect_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      // Tags are popped for dropped responses too, keeping them aligned with the in-order memory.
      if (gnt_hs) tag_wr_q <= tag_next(tag_wr_q);
      if (rsp)    tag_rd_q <= tag_next(tag_rd_q);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH:   if (redirect_i && disc_d != '0) state_q <= DRAIN;
        DRAIN:   if (disc_d == '0) state_q <= FETCH;
        default: state_q <= FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else if (wr_en) begin
      fifo_q[wr_ptr_q] <= {tag_q[tag_rd_q], imem_rdata_i};
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_hs) tag_q[tag_wr_q] <= fetch_pc_i;
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] disc_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      disc_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (drop && disc_cnt_q != '1) disc_cnt_q <= disc_cnt_q + 32'd1;
      if (fetch_stall_o && state_q == FETCH && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_discard_cnt_o = disc_cnt_q;
  assign perf_stall_cnt_o   = stall_cnt_q;
`else
  assign perf_discard_cnt_o = 32'h0;
  assign perf_stall_cnt_o   = 32'h0;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios plus randomized traffic, checked cycle by cycle against a
// queue-based model of the fetch pipeline and an in-order memory responder.
module tb_ifetch_queue;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [31:0] fetch_pc = 32'h0;
  logic        redirect = 1'b0, gnt = 1'b0, rvalid = 1'b0, id_ready = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        fetch_stall, imem_req, if_valid, dbg_state;
  logic [31:0] imem_addr, if_pc, if_inst, perf_discard_cnt, perf_stall_cnt;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rstn(rstn),
    .fetch_pc_i(fetch_pc), .redirect_i(redirect), .fetch_stall_o(fetch_stall),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .if_valid_o(if_valid), .if_pc_o(if_pc), .if_inst_o(if_inst), .id_ready_i(id_ready),
    .perf_discard_cnt_o(perf_discard_cnt), .perf_stall_cnt_o(perf_stall_cnt),
    .dbg_state_o(dbg_state)
  );

  int n_assert = 0, n_fail = 0;
  int p_gnt, p_rv, p_rdy, p_redir, lat_extra, cyc = 0;
  logic force_redir = 1'b0, force_rv = 1'b0;
  logic [31:0] redir_target, pc_next;
  logic [31:0] mem_addr_q[$];
  int          mem_rdy_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] inf_pc[$];
  bit          inf_stale[$];
  logic [31:0] pop_obs[$];
  int m_discards, m_stalls, obs_grants;
  logic obs_req, obs_stall, obs_valid, obs_state;
  logic [31:0] obs_addr, obs_pc;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit has_stale();
    foreach (inf_stale[i]) if (inf_stale[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [31:0] pc0);
    rstn = 1'b1;
    #1 rstn = 1'b0;
    gnt = 0; redirect = 0; rvalid = 0; id_ready = 0; rdata = 0; force_redir = 0; force_rv = 0;
    fetch_pc = pc0;
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_fetch_stall", fetch_stall, 1);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_if_inst", if_inst, 0);
    chk("rst_perf_discard", perf_discard_cnt, 0);
    chk("rst_perf_stall", perf_stall_cnt, 0);
    chk("rst_state", dbg_state, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    mem_addr_q.delete(); mem_rdy_q.delete(); exp_q.delete(); inf_pc.delete(); inf_stale.delete();
    pop_obs.delete();
    pc_next = pc0; m_discards = 0; m_stalls = 0; obs_grants = 0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check against the model, then advance the model.
  task automatic step();
    logic m_req, m_stall, granted, stale;
    logic [31:0] pc;
    @(negedge clk);
    id_ready = ($urandom_range(0, 99) < p_rdy);
    gnt      = ($urandom_range(0, 99) < p_gnt);
    redirect = force_redir || ($urandom_range(0, 99) < p_redir);
    if (redirect && !force_redir) redir_target = $urandom & 32'hFFFF_FFFC;
    fetch_pc = pc_next;
    rvalid = 1'b0;
    rdata  = $urandom;
    if (force_rv) rvalid = 1'b1;
    else if (mem_addr_q.size() > 0 && mem_rdy_q[0] <= cyc && $urandom_range(0, 99) < p_rv) begin
      rvalid = 1'b1;
      rdata  = data_of(mem_addr_q[0]);
    end
    #1;
    m_req = !redirect && !has_stale() && (exp_q.size() + inf_pc.size() < DEPTH) && (inf_pc.size() < MAX_OUT);
    m_stall = !(m_req && gnt);
    chk("imem_req", imem_req, m_req);
    chk("fetch_stall", fetch_stall, m_stall);
    chk("imem_addr", imem_addr, fetch_pc);
    chk("if_valid", if_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      chk("if_pc", if_pc, exp_q[0][63:32]);
      chk("if_inst", if_inst, exp_q[0][31:0]);
    end
    chk("state_drain", dbg_state, has_stale());
`ifdef IFETCH_PERF_EN
    chk("perf_discard", perf_discard_cnt, m_discards);
    chk("perf_stall", perf_stall_cnt, m_stalls);
`else
    chk("perf_discard", perf_discard_cnt, 0);
    chk("perf_stall", perf_stall_cnt, 0);
`endif
    obs_req = imem_req; obs_stall = fetch_stall; obs_valid = if_valid; obs_state = dbg_state;
    obs_addr = imem_addr; obs_pc = if_pc;
    if (imem_req && gnt) obs_grants++;
    if (if_valid && id_ready) pop_obs.push_back(if_pc);
    granted = m_req && gnt;
    if (m_stall && !has_stale()) m_stalls++;
    if (id_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    if (rvalid && inf_pc.size() > 0) begin
      pc = inf_pc.pop_front();
      stale = inf_stale.pop_front();
      if (stale) m_discards++;
      else exp_q.push_back({pc, rdata});
    end
    if (rvalid && mem_addr_q.size() > 0) begin
      void'(mem_addr_q.pop_front());
      void'(mem_rdy_q.pop_front());
    end
    if (granted) begin
      inf_pc.push_back(fetch_pc);
      inf_stale.push_back(1'b0);
      mem_addr_q.push_back(fetch_pc);
      mem_rdy_q.push_back(cyc + 1 + int'($urandom_range(0, lat_extra)));
    end
    if (redirect) begin
      exp_q.delete();
      foreach (inf_stale[i]) inf_stale[i] = 1'b1;
      pc_next = redir_target;
    end else if (granted) begin
      pc_next = fetch_pc + 32'd4;
    end
    cyc++;
  endtask

  initial begin
    p_gnt = 100; p_rv = 100; p_rdy = 100; p_redir = 0; lat_extra = 0; redir_target = 32'h200;

    // Streaming at full rate.
    do_reset(32'h64);
    repeat (2) step();
    for (int i = 0; i < 28; i++) begin
      step();
      chk("stream_no_stall", obs_stall, 0);
    end
    chk("stream_pc0", pop_obs[0], 32'h64);
    chk("stream_pc1", pop_obs[1], 32'h68);
    chk("stream_pc2", pop_obs[2], 32'h6C);

    // Spurious response with nothing outstanding is ignored.
    do_reset(32'h64);
    p_gnt = 0; force_rv = 1'b1;
    step();
    force_rv = 1'b0;
    step();
    chk("spurious_rsp_valid", obs_valid, 0);

    // Backpressure: decode stalled fills exactly DEPTH entries.
    do_reset(32'h64);
    p_gnt = 100; p_rdy = 0;
    repeat (12) step();
    chk("bp_grants", obs_grants, 4);
    chk("bp_req_low", obs_req, 0);
    chk("bp_stall_high", obs_stall, 1);
    p_rdy = 100; step();
    p_rdy = 0; repeat (8) step();
    chk("bp_one_more", obs_grants, 5);

    // Redirect with two outstanding requests.
    do_reset(32'h80);
    p_rv = 0; p_rdy = 100;
    repeat (3) step();
    chk("redir2_grants", obs_grants, 2);
    force_redir = 1'b1; redir_target = 32'h200;
    step();
    force_redir = 1'b0; p_rv = 100;
    step();
    chk("redir2_drain", obs_state, 1);
    pop_obs.delete();
    repeat (15) step();
    chk("redir2_first_pc", pop_obs[0], 32'h200);
`ifdef IFETCH_PERF_EN
    chk("redir2_perf_discard", perf_discard_cnt, 2);
`endif

    // Redirect with nothing outstanding and three queued entries.
    do_reset(32'h64);
    p_rdy = 0;
    for (int i = 0; i < 20 && obs_grants < 3; i++) step();
    p_gnt = 0;
    repeat (4) step();
    chk("redir0_queued", obs_valid, 1);
    force_redir = 1'b1; redir_target = 32'h200; p_gnt = 100;
    step();
    force_redir = 1'b0;
    step();
    chk("redir0_flushed", obs_valid, 0);
    chk("redir0_req", obs_req, 1);
    chk("redir0_addr", obs_addr, 32'h200);

    // Slow memory: grant withheld for three cycles.
    do_reset(32'h64);
    p_gnt = 0; p_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("slow_req", obs_req, 1);
      chk("slow_addr", obs_addr, 32'h64);
      chk("slow_stall", obs_stall, 1);
    end
    p_gnt = 100; step();
    p_gnt = 0; repeat (4) step();
    chk("slow_grants", obs_grants, 1);
    chk("slow_entry", obs_valid, 1);
    chk("slow_pc", obs_pc, 32'h64);

    // Asynchronous reset while draining.
    do_reset(32'h80);
    p_gnt = 100; p_rv = 0; p_rdy = 100;
    repeat (3) step();
    force_redir = 1'b1; redir_target = 32'h200;
    step();
    force_redir = 1'b0;
    step();
    chk("mid_drain_state", obs_state, 1);
    do_reset(32'h300);
    p_rv = 100;
    step();
    chk("post_rst_req", obs_req, 1);
    chk("post_rst_addr", obs_addr, 32'h300);

    // Randomized traffic with redirects and one mid-run reset.
    do_reset(32'h1000);
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) begin
        p_gnt = $urandom_range(20, 100); p_rv = $urandom_range(30, 100);
        p_rdy = $urandom_range(10, 100); p_redir = $urandom_range(0, 8);
        lat_extra = $urandom_range(0, 3);
      end
      if (i == 400) do_reset($urandom & 32'hFFFF_FFFC);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
